// File: rtl/timer_multi.sv
// timer_multi: N_CH independent down-counting timers behind a small word-addressed
// register bus. Each channel has CTRL, PRESET, COUNT (read-only) and STATUS,
// an 8-bit prescaler, one-shot or auto-reload expiry, and a maskable interrupt.
module timer_multi #(
  parameter int  N_CH    = 2,
  parameter int  WIDTH   = 32,
  localparam int CH_BITS = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH_BITS+3:2]   DEV_Addr,
  input  logic                 WeDEV,
  input  logic [31:0]          DEV_WD,
  output logic [31:0]          DEV_RD,
  output logic [N_CH-1:0]      DEV_irq,
  output logic                 DEV_break
);

  logic [CH_BITS-1:0] ch_sel;
  logic [1:0]         reg_sel;
  logic [31:0]        rd_ch [N_CH];

  assign ch_sel  = DEV_Addr[CH_BITS+3:4];
  assign reg_sel = DEV_Addr[3:2];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             en_reg, en_next;
    logic [1:0]       mode_reg, mode_next;
    logic             im_reg, im_next;
    logic [7:0]       psc_reg, psc_next;
    logic [7:0]       psc_cnt_reg, psc_cnt_next;
    logic [WIDTH-1:0] preset_reg, preset_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             pending_reg, pending_next;
    logic             wr_sel, ctrl_wr, preset_wr, status_wr;
    logic             tick, expire, auto_reload;
    logic [31:0]      rd_val;

    assign wr_sel      = WeDEV && (ch_sel == CH_BITS'(gi));
    assign ctrl_wr     = wr_sel && (reg_sel == 2'b00);
    assign preset_wr   = wr_sel && (reg_sel == 2'b01);
    assign status_wr   = wr_sel && (reg_sel == 2'b11);
    // Reserved modes (1x) behave as one-shot, so only 01 reloads.
    assign auto_reload = (mode_reg == 2'b01);
    assign tick        = en_reg && (psc_cnt_reg == psc_reg);
    assign expire      = tick && (count_reg == '0);

    // Next-state: prescaler, count/reload, expiry, then bus writes (writes take priority
    // over the one-shot EN clear; an expiry beats a same-cycle pending clear).
    always_comb begin
      en_next      = en_reg;
      mode_next    = mode_reg;
      im_next      = im_reg;
      psc_next     = psc_reg;
      preset_next  = preset_reg;
      count_next   = count_reg;
      pending_next = pending_reg;
      psc_cnt_next = psc_cnt_reg + 8'd1;
      if (!en_reg || ctrl_wr || tick) begin
        psc_cnt_next = '0;
      end
      if (tick) begin
        if (count_reg != '0) begin
          count_next = count_reg - WIDTH'(1);
        end else if (auto_reload) begin
          count_next = preset_reg;
        end
      end
      if (expire) begin
        pending_next = 1'b1;
        if (!auto_reload) begin
          en_next = 1'b0;
        end
      end
      if (status_wr && DEV_WD[0] && !expire) begin
        pending_next = 1'b0;
      end
      if (preset_wr) begin
        preset_next = DEV_WD[WIDTH-1:0];
        if (!en_reg) begin
          count_next = DEV_WD[WIDTH-1:0];
        end
      end
      if (ctrl_wr) begin
        en_next   = DEV_WD[0];
        mode_next = DEV_WD[2:1];
        im_next   = DEV_WD[3];
        psc_next  = DEV_WD[15:8];
      end
    end

    // State register with synchronous reset overriding any write.
    always_ff @(posedge clk) begin
      if (reset) begin
        en_reg      <= 1'b0;
        mode_reg    <= '0;
        im_reg      <= 1'b0;
        psc_reg     <= '0;
        psc_cnt_reg <= '0;
        preset_reg  <= '0;
        count_reg   <= '0;
        pending_reg <= 1'b0;
      end else begin
        en_reg      <= en_next;
        mode_reg    <= mode_next;
        im_reg      <= im_next;
        psc_reg     <= psc_next;
        psc_cnt_reg <= psc_cnt_next;
        preset_reg  <= preset_next;
        count_reg   <= count_next;
        pending_reg <= pending_next;
      end
    end

    // Register read view for this channel; unused bits read as zero.
    always_comb begin
      rd_val = '0;
      case (reg_sel)
        2'b00:   rd_val = {16'h0000, psc_reg, 4'h0, im_reg, mode_reg, en_reg};
        2'b01:   rd_val = 32'(preset_reg);
        2'b10:   rd_val = 32'(count_reg);
        default: rd_val = {31'h0, pending_reg};
      endcase
    end

    assign rd_ch[gi]   = rd_val;
    assign DEV_irq[gi] = pending_reg & im_reg;
  end

  assign DEV_RD    = rd_ch[ch_sel];
  assign DEV_break = |DEV_irq;

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: the driver applies one bus cycle at a time,
// pushes the response predicted by a behavioural model, and a monitor compares
// DEV_RD / DEV_irq / DEV_break at every falling edge.
module tb_timer_multi;
  localparam int N = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:2]    DEV_Addr;
  logic          WeDEV;
  logic [31:0]   DEV_WD;
  logic [31:0]   DEV_RD;
  logic [N-1:0]  DEV_irq;
  logic          DEV_break;

  always #5 clk = ~clk;

  timer_multi #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .DEV_Addr(DEV_Addr), .WeDEV(WeDEV),
    .DEV_WD(DEV_WD), .DEV_RD(DEV_RD), .DEV_irq(DEV_irq), .DEV_break(DEV_break)
  );

  // Behavioural model: ticks are derived from cycles elapsed since enable
  // (first tick after PSC+1 cycles, then every PSC+1 cycles).
  bit          m_en   [N];
  bit [1:0]    m_mode [N];
  bit          m_im   [N];
  bit [7:0]    m_psc  [N];
  logic [31:0] m_preset [N];
  logic [31:0] m_count  [N];
  bit          m_pend [N];
  int unsigned m_age  [N];

  typedef struct {
    logic [31:0]  rd;
    logic [N-1:0] irq;
    int           ch;
    int           rg;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  function automatic logic [31:0] m_read(int c, int r);
    case (r)
      0:       return {16'h0000, m_psc[c], 4'h0, m_im[c], m_mode[c], m_en[c]};
      1:       return m_preset[c];
      2:       return m_count[c];
      default: return {31'h0, m_pend[c]};
    endcase
  endfunction

  function automatic logic [N-1:0] m_irq();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_pend[c] & m_im[c];
    return v;
  endfunction

  task automatic m_step(bit rst, bit we, int ch, int rg, logic [31:0] wd);
    for (int c = 0; c < N; c++) begin
      bit tick, wr, expire, en_now;
      if (rst) begin
        m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0;
        m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0; m_age[c] = 0;
        continue;
      end
      en_now = m_en[c];
      tick   = en_now && ((m_age[c] % (int'(m_psc[c]) + 1)) == int'(m_psc[c]));
      wr     = we && (ch == c);
      expire = tick && (m_count[c] == 0);
      if (tick) begin
        if (m_count[c] != 0) m_count[c] = m_count[c] - 1;
        else if (m_mode[c] == 2'd1) m_count[c] = m_preset[c];
      end
      m_age[c] = en_now ? m_age[c] + 1 : 0;
      if (expire) begin
        m_pend[c] = 1;
        if (m_mode[c] != 2'd1) m_en[c] = 0;
      end
      if (wr) begin
        case (rg)
          0: begin
            m_en[c] = wd[0]; m_mode[c] = wd[2:1]; m_im[c] = wd[3];
            m_psc[c] = wd[15:8]; m_age[c] = 0;
          end
          1: begin
            m_preset[c] = wd;
            if (!en_now) m_count[c] = wd;
          end
          3: if (wd[0] && !expire) m_pend[c] = 0;
          default: ;
        endcase
      end
    end
  endtask

  // One bus cycle: drive, predict the response of the current state, advance model.
  task automatic cyc(bit rst, bit we, int ch, int rg, logic [31:0] wd);
    exp_t e;
    reset    = rst;
    WeDEV    = we;
    DEV_Addr = {2'(ch), 2'(rg)};
    DEV_WD   = wd;
    e.rd  = m_read(ch, rg);
    e.irq = m_irq();
    e.ch  = ch;
    e.rg  = rg;
    sb.push_back(e);
    m_step(rst, we, ch, rg, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int ch, int rg);
    cyc(0, 0, ch, rg, 32'h0);
  endtask

  task automatic wr(int ch, int rg, logic [31:0] wd);
    cyc(0, 1, ch, rg, wd);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d ch%0d reg%0d rd=%h irq=%b brk=%b", txn, e.ch, e.rg, DEV_RD, DEV_irq, DEV_break);
        checks++;
        if (DEV_RD !== e.rd) begin
          errors++;
          $display("FAIL rd ch%0d reg%0d got=%h exp=%h", e.ch, e.rg, DEV_RD, e.rd);
        end
        checks++;
        if (DEV_irq !== e.irq) begin
          errors++;
          $display("FAIL irq got=%b exp=%b", DEV_irq, e.irq);
        end
        checks++;
        if (DEV_break !== (|e.irq)) begin
          errors++;
          $display("FAIL break got=%b exp=%b", DEV_break, |e.irq);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    bit          r_rst, r_we;
    int          r_ch, r_rg;
    reset = 1'b1; WeDEV = 1'b0; DEV_Addr = '0; DEV_WD = '0;
    @(posedge clk);
    #1;
    m_step(1, 0, 0, 0, 32'h0);
    for (int r = 0; r < 4; r++) rd(0, r);

    // One-shot on ch0: PRESET=3, enable with IM.
    wr(0, 1, 32'd3);
    wr(0, 0, 32'h9);
    for (int i = 0; i < 6; i++) rd(0, 2);
    rd(0, 3); rd(0, 0);

    // Auto-reload on ch1, period 3: clear on the expiry cycle, then between expiries.
    wr(1, 1, 32'd2);
    wr(1, 0, 32'h0B);
    rd(1, 2); rd(1, 2);
    wr(1, 3, 32'h1);
    rd(1, 3);
    wr(1, 3, 32'h1);
    for (int i = 0; i < 5; i++) rd(1, 3);
    wr(1, 2, 32'h55);
    rd(1, 2);

    // Prescaled auto-reload on ch2: PRESET=1, PSC=3.
    wr(2, 1, 32'd1);
    wr(2, 0, 32'h30B);
    for (int i = 0; i < 18; i++) rd(2, 2);

    // ch3: PRESET rewrite while running, IM=0.
    wr(3, 1, 32'd4);
    wr(3, 0, 32'h3);
    rd(3, 2); rd(3, 2);
    wr(3, 1, 32'd5);
    for (int i = 0; i < 5; i++) rd(3, 2);
    rd(3, 3); rd(3, 1);

    // CTRL write colliding with a one-shot expiry on ch0.
    wr(0, 3, 32'h1);
    wr(0, 1, 32'd2);
    wr(0, 0, 32'h9);
    rd(0, 2); rd(0, 2);
    wr(0, 0, 32'h9);
    for (int i = 0; i < 3; i++) rd(0, 0);

    // Reset mid-count, including a simultaneous write, then read everything.
    cyc(1, 1, 0, 0, 32'h9);
    for (int c = 0; c < N; c++)
      for (int r = 0; r < 4; r++) rd(c, r);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = ($urandom_range(0, 9) < 4);
      r_ch  = $urandom_range(0, N - 1);
      r_rg  = $urandom_range(0, 3);
      wd    = $urandom;
      if (r_rg == 0) begin
        wd[15:8] = 8'($urandom_range(0, 3));
        wd[0]    = ($urandom_range(0, 3) != 0);
      end
      if (r_rg == 1 && $urandom_range(0, 7) != 0) wd = $urandom_range(0, 6);
      cyc(r_rst, r_we, r_ch, r_rg, wd);
    end
    rd(0, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Parameters
REQ-001 The block SHALL have parameter N_CH, default 2: number of independent timer channels, a power of two in the range 2..8.
REQ-002 The block SHALL have parameter WIDTH, default 32: counter and preset width, in the range 8..32.
REQ-003 The block SHALL derive CH_BITS = log2(N_CH) and SHALL NOT expose it as an override.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port DEV_Addr, input, [CH_BITS+3:2]: word address; [CH_BITS+3:4] selects the channel, [3:2] selects the register.
REQ-007 The block SHALL have port WeDEV, input, 1 bit: write enable.
REQ-008 The block SHALL have port DEV_WD, input, 32 bits: write data.
REQ-009 The block SHALL have port DEV_RD, output, 32 bits: read data, combinational from DEV_Addr.
REQ-010 The block SHALL have port DEV_irq, output, N_CH bits: per-channel interrupt, bit i = pending_i & IM_i.
REQ-011 The block SHALL have port DEV_break, output, 1 bit: OR of DEV_irq.

Function
REQ-012 Each channel SHALL have four registers, selected by [3:2]: 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 STATUS.
REQ-013 CTRL fields SHALL be: [0] EN; [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved and treated as one-shot); [3] IM (interrupt enable); [15:8] PSC (prescale). All other bits SHALL read 0.
REQ-014 PRESET and COUNT SHALL be WIDTH bits wide, written from DEV_WD[WIDTH-1:0] and zero-extended on read.
REQ-015 STATUS bit 0 SHALL be pending; writing 1 to it SHALL clear it, and writing 0 SHALL have no effect. All other bits SHALL read 0.
REQ-016 Writes to COUNT SHALL be ignored.
REQ-017 Each channel SHALL have a prescale counter psc_cnt (8 bits); while EN=1 it SHALL assert tick when psc_cnt==PSC and then wrap to 0, otherwise increment.
REQ-018 psc_cnt SHALL be held at 0 while EN=0 and on any CTRL write.
REQ-019 With PSC=0, tick SHALL assert every cycle while EN=1, so the decrement rate is one per (PSC+1) cycles.
REQ-020 On a tick with COUNT>0, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT==0, the channel SHALL expire: pending is set to 1.
REQ-022 On expiry in one-shot mode, EN SHALL be cleared and COUNT SHALL stay 0.
REQ-023 On expiry in auto-reload mode, COUNT SHALL reload from PRESET, giving a period of (PRESET+1)*(PSC+1) cycles; PRESET=0 expires on every tick.
REQ-024 A PRESET write SHALL always update PRESET, and SHALL also load COUNT only if EN=0; while EN=1 the new value takes effect at the next reload.
REQ-025 A CTRL write SHALL NOT alter COUNT or PRESET; setting EN 0->1 SHALL start counting from the current COUNT with the first tick PSC+1 cycles later.
REQ-026 When a STATUS clear and an expiry occur in the same cycle, the set SHALL win and pending SHALL remain 1.
REQ-027 When a CTRL write and a one-shot auto-clear of EN occur in the same cycle, the CTRL write SHALL win.
REQ-028 Channels SHALL be fully independent; a write SHALL affect only the addressed channel.
REQ-029 DEV_irq and DEV_break SHALL be combinational from registered state and SHALL have no added latency beyond the expiry edge.

Reset
REQ-030 While reset=1 at a clk edge, all CTRL, PRESET, COUNT, pending and psc_cnt SHALL become 0, giving DEV_irq=0 and DEV_break=0; reset SHALL override simultaneous writes.
REQ-031 Asserting reset mid-count SHALL abort the count with no expiry event.

Verification
REQ-032 Ch0 PRESET=3, CTRL=0x9 (one-shot, IM, EN) -> COUNT 3,2,1,0 on successive cycles; pending=1, DEV_break=1 and EN=0 at the 4th tick edge after enable; COUNT stays 0.
REQ-033 Ch1 PRESET=2, CTRL=0x0B (auto-reload, IM, EN) -> expiries every 3 cycles; write STATUS=1 between expiries -> DEV_irq[1] drops, then re-asserts at the next expiry.
REQ-034 PRESET=1, PSC=3, auto-reload, EN -> COUNT changes only every 4 cycles; expiry period = 8 cycles.
REQ-035 STATUS clear issued on the exact expiry cycle -> pending stays 1.
REQ-036 PRESET=5 written while EN=1 and COUNT=2 -> COUNT continues 1,0, then reloads to 5; with IM=0 -> pending sets but DEV_break stays 0.
REQ-037 Reset asserted mid-count on all channels -> every register reads 0 on the next cycle and DEV_break=0.
